// File: rtl/noc_vc_link_arbiter.sv
// Virtual-channel link arbiter: picks one VC FIFO head per cycle, forwards it as a
// registered flit, keeps wormhole packets contiguous and tracks downstream credits.
module noc_vc_link_arbiter #(
    parameter int CHANNELS   = 2,
    parameter int FLIT_WIDTH = 32,
    parameter int CREDITS    = 8,
    parameter int CW         = $clog2(CREDITS + 1)
) (
    input  logic                           noc_clk,
    input  logic                           noc_rst_n,
    input  logic                           i_clear,
    input  logic [CHANNELS-1:0]            i_valid,
    input  logic [CHANNELS*FLIT_WIDTH-1:0] i_flit,
    output logic [CHANNELS-1:0]            o_pop,
    output logic [CHANNELS-1:0]            o_valid,
    output logic [FLIT_WIDTH-1:0]          o_flit,
    input  logic [CHANNELS-1:0]            i_credit_return,
    output logic                           o_credit_err,
    output logic                           o_locked
);
    localparam int VW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

    lock_state_e             state_q, state_d;
    logic [VW-1:0]           lock_vc_q, lock_vc_d;
    logic [VW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]           credit_q [CHANNELS];
    logic [CW-1:0]           credit_d [CHANNELS];
    logic [CHANNELS-1:0]     valid_q, valid_d;
    logic [FLIT_WIDTH-1:0]   flit_q, flit_d;
    logic                    err_q, err_d;

    logic [CHANNELS-1:0]     eligible;
    logic [CHANNELS-1:0]     grant;
    logic [VW-1:0]           win;
    logic                    found;
    logic [FLIT_WIDTH-1:0]   sel_flit;
    logic                    sel_head, sel_tail;
    int                      idx;

    always_comb begin
        for (int v = 0; v < CHANNELS; v++) begin
            eligible[v] = i_valid[v] && (credit_q[v] != '0);
        end
    end

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        grant = '0;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        if (state_q == LOCKED) begin
            // A held lock blocks every other VC, even when the locked one cannot send.
            if (eligible[lock_vc_q]) begin
                grant[lock_vc_q] = 1'b1;
                win              = lock_vc_q;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                idx = int'(rr_ptr_q) + i;
                if (idx >= CHANNELS) idx = idx - CHANNELS;
                if (!found && eligible[idx]) begin
                    found      = 1'b1;
                    grant[idx] = 1'b1;
                    win        = VW'(idx);
                end
            end
        end
    end

    assign sel_flit = i_flit[int'(win)*FLIT_WIDTH +: FLIT_WIDTH];
    assign sel_head = sel_flit[FLIT_WIDTH-1];
    assign sel_tail = sel_flit[FLIT_WIDTH-2];

    always_comb begin
        state_d   = state_q;
        lock_vc_d = lock_vc_q;
        rr_ptr_d  = rr_ptr_q;
        valid_d   = grant;
        flit_d    = flit_q;
        err_d     = err_q;
        if (|grant) begin
            flit_d   = sel_flit;
            rr_ptr_d = (int'(win) + 1 >= CHANNELS) ? '0 : win + VW'(1);
            if (state_q == IDLE && sel_head && !sel_tail) begin
                state_d   = LOCKED;
                lock_vc_d = win;
            end else if (state_q == LOCKED && sel_tail) begin
                state_d = IDLE;
            end
        end
        for (int v = 0; v < CHANNELS; v++) begin
            credit_d[v] = credit_q[v];
            if (grant[v] && !i_credit_return[v]) begin
                credit_d[v] = credit_q[v] - CW'(1);
            end else if (!grant[v] && i_credit_return[v]) begin
                if (credit_q[v] == CW'(CREDITS)) err_d = 1'b1;
                else                             credit_d[v] = credit_q[v] + CW'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge noc_clk) begin
        if (!noc_rst_n || i_clear) begin
            state_q   <= IDLE;
            lock_vc_q <= '0;
            rr_ptr_q  <= '0;
            valid_q   <= '0;
            flit_q    <= '0;
            err_q     <= 1'b0;
            for (int v = 0; v < CHANNELS; v++) credit_q[v] <= CW'(CREDITS);
        end else begin
            state_q   <= state_d;
            lock_vc_q <= lock_vc_d;
            rr_ptr_q  <= rr_ptr_d;
            valid_q   <= valid_d;
            flit_q    <= flit_d;
            err_q     <= err_d;
            credit_q  <= credit_d;
        end
    end

    assign o_pop        = grant;
    assign o_valid      = valid_q;
    assign o_flit       = flit_q;
    assign o_credit_err = err_q;
    assign o_locked     = (state_q == LOCKED);
endmodule

// File: tb/tb_noc_vc_link_arbiter.sv
// Directed bench: instance "a" uses 8 credits per VC, instance "b" uses 2 so
// exhaustion, starvation and reset-restore scenarios stay short.
module tb_noc_vc_link_arbiter;
    localparam logic [31:0] HT0 = 32'hC00000A0;
    localparam logic [31:0] HT1 = 32'hC00000B1;
    localparam logic [31:0] H0  = 32'h80000010;
    localparam logic [31:0] B0  = 32'h00000011;
    localparam logic [31:0] B0B = 32'h00000012;
    localparam logic [31:0] T0  = 32'h40000013;
    localparam logic [31:0] H1  = 32'h800000B1;
    localparam logic [31:0] T1  = 32'h400000B2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst_n, a_clear, a_err, a_lk;
    logic [1:0]  a_valid, a_ret, a_pop, a_ov;
    logic [63:0] a_flit;
    logic [31:0] a_of;
    logic        b_rst_n, b_clear, b_err, b_lk;
    logic [1:0]  b_valid, b_ret, b_pop, b_ov;
    logic [63:0] b_flit;
    logic [31:0] b_of;

    int checks = 0;
    int errors = 0;

    noc_vc_link_arbiter #(.CHANNELS(2), .FLIT_WIDTH(32), .CREDITS(8)) dut_a (
        .noc_clk(clk), .noc_rst_n(a_rst_n), .i_clear(a_clear),
        .i_valid(a_valid), .i_flit(a_flit), .o_pop(a_pop),
        .o_valid(a_ov), .o_flit(a_of), .i_credit_return(a_ret),
        .o_credit_err(a_err), .o_locked(a_lk)
    );

    noc_vc_link_arbiter #(.CHANNELS(2), .FLIT_WIDTH(32), .CREDITS(2)) dut_b (
        .noc_clk(clk), .noc_rst_n(b_rst_n), .i_clear(b_clear),
        .i_valid(b_valid), .i_flit(b_flit), .o_pop(b_pop),
        .o_valid(b_ov), .o_flit(b_of), .i_credit_return(b_ret),
        .o_credit_err(b_err), .o_locked(b_lk)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_rst_n = 1'b0; a_clear = 1'b0; a_valid = '0; a_ret = '0; a_flit = '0;
        b_rst_n = 1'b0; b_clear = 1'b0; b_valid = '0; b_ret = '0; b_flit = '0;
        cyc(); cyc();
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        #1;
        check("rst_valid",  32'(a_ov),  0);
        check("rst_flit",   a_of,       0);
        check("rst_err",    32'(a_err), 0);
        check("rst_locked", 32'(a_lk),  0);
        check("rst_pop",    32'(a_pop), 0);
        cyc(); cyc();
        check("idle_valid",  32'(a_ov),  0);
        check("idle_pop",    32'(a_pop), 0);
        check("idle_locked", 32'(a_lk),  0);

        // Returns while already full: error after the first, sticky afterwards.
        a_ret = 2'b01;
        cyc();
        check("cerr_first", 32'(a_err), 1);
        repeat (7) cyc();
        a_ret = 2'b00;
        cyc();
        check("cerr_sticky", 32'(a_err), 1);
        a_clear = 1'b1;
        cyc();
        a_clear = 1'b0;
        #1;
        check("cerr_cleared", 32'(a_err), 0);

        // Single-flit packets on both VCs alternate.
        a_flit = {HT1, HT0}; a_valid = 2'b11;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("alt_pop", 32'(a_pop), (i % 2 == 0) ? 1 : 2);
            cyc();
            check("alt_valid", 32'(a_ov), (i % 2 == 0) ? 1 : 2);
            check("alt_flit",  a_of,      (i % 2 == 0) ? HT0 : HT1);
        end

        // Wormhole: VC0 H,B,B,T keeps the link while VC1 waits.
        a_valid = 2'b00; a_clear = 1'b1;
        cyc();
        a_clear = 1'b0;
        a_valid = 2'b11; a_flit = {HT1, H0};
        #1;
        check("wh_pop_h", 32'(a_pop), 1);
        check("wh_lk_h",  32'(a_lk),  0);
        cyc();
        check("wh_ov_h", 32'(a_ov), 1);
        check("wh_of_h", a_of,      H0);
        check("wh_lk_1", 32'(a_lk), 1);
        a_flit = {HT1, B0};
        #1;
        check("wh_pop_b1", 32'(a_pop), 1);
        cyc();
        check("wh_ov_b1", 32'(a_ov), 1);
        check("wh_of_b1", a_of,      B0);
        a_flit = {HT1, B0B};
        #1;
        check("wh_pop_b2", 32'(a_pop), 1);
        cyc();
        check("wh_ov_b2", 32'(a_ov), 1);
        check("wh_of_b2", a_of,      B0B);
        a_flit = {HT1, T0};
        #1;
        check("wh_pop_t", 32'(a_pop), 1);
        check("wh_lk_t",  32'(a_lk),  1);
        cyc();
        check("wh_ov_t", 32'(a_ov), 1);
        check("wh_of_t", a_of,      T0);
        check("wh_lk_0", 32'(a_lk), 0);
        a_flit = {HT1, HT0};
        #1;
        check("wh_pop_vc1", 32'(a_pop), 2);
        cyc();
        check("wh_ov_vc1", 32'(a_ov), 2);
        check("wh_of_vc1", a_of,      HT1);
        a_valid = 2'b00;

        // Credit exhaustion with 2 credits.
        b_valid = 2'b01; b_flit = {HT1, HT0};
        #1;
        check("ex_pop1", 32'(b_pop), 1);
        cyc();
        check("ex_ov1",  32'(b_ov),  1);
        check("ex_pop2", 32'(b_pop), 1);
        cyc();
        check("ex_ov2",  32'(b_ov),  1);
        check("ex_pop3", 32'(b_pop), 0);
        cyc();
        check("ex_ov3",  32'(b_ov),  0);
        check("ex_of_hold", b_of, HT0);
        b_ret = 2'b01;
        #1;
        check("ex_ret_pop", 32'(b_pop), 0);
        cyc();
        b_ret = 2'b00;
        #1;
        check("ex_one_more", 32'(b_pop), 1);
        cyc();
        check("ex_one_ov",   32'(b_ov),  1);
        check("ex_none",     32'(b_pop), 0);
        // One credit back, then grant and return together twice: count holds at 1.
        b_ret = 2'b01;
        cyc();
        #1;
        check("sim_pop0", 32'(b_pop), 1);
        cyc();
        check("sim_pop1", 32'(b_pop), 1);
        cyc();
        check("sim_pop2", 32'(b_pop), 1);
        b_ret = 2'b00;
        cyc();
        check("sim_ov",   32'(b_ov),  1);
        check("sim_pop3", 32'(b_pop), 0);
        check("sim_err",  32'(b_err), 0);

        // Locked VC0 out of credits starves VC1.
        b_valid = 2'b00; b_clear = 1'b1;
        cyc();
        b_clear = 1'b0;
        b_valid = 2'b11; b_flit = {HT1, H0};
        #1;
        check("st_pop_h", 32'(b_pop), 1);
        cyc();
        check("st_lk", 32'(b_lk), 1);
        b_flit = {HT1, B0};
        #1;
        check("st_pop_b", 32'(b_pop), 1);
        cyc();
        check("st_blocked", 32'(b_pop), 0);
        cyc();
        check("st_ov_idle", 32'(b_ov), 0);
        check("st_lk_held", 32'(b_lk), 1);
        cyc();
        check("st_ov_idle2", 32'(b_ov), 0);
        b_ret = 2'b01;
        #1;
        check("st_ret_pop", 32'(b_pop), 0);
        cyc();
        b_ret = 2'b00; b_flit = {HT1, T0};
        #1;
        check("st_resume", 32'(b_pop), 1);
        cyc();
        check("st_ov_t", 32'(b_ov), 1);
        check("st_of_t", b_of,      T0);
        check("st_lk_0", 32'(b_lk), 0);
        check("st_vc1",  32'(b_pop), 2);

        // Reset mid-packet drops the lock and restores credits.
        b_valid = 2'b00; b_clear = 1'b1;
        cyc();
        b_clear = 1'b0;
        b_valid = 2'b01; b_flit = {H1, H0};
        #1;
        check("rm_pop_h", 32'(b_pop), 1);
        cyc();
        check("rm_lk", 32'(b_lk), 1);
        b_rst_n = 1'b0; b_valid = 2'b10;
        cyc();
        b_rst_n = 1'b1;
        #1;
        check("rm_lk_0", 32'(b_lk),  0);
        check("rm_ov_0", 32'(b_ov),  0);
        check("rm_of_0", b_of,       0);
        check("rm_pop1", 32'(b_pop), 2);
        cyc();
        check("rm_ov1", 32'(b_ov), 2);
        check("rm_of1", b_of,      H1);
        check("rm_lk1", 32'(b_lk), 1);
        b_flit = {T1, H0};
        #1;
        check("rm_pop_t1", 32'(b_pop), 2);
        cyc();
        check("rm_lk_end", 32'(b_lk), 0);
        b_valid = 2'b01; b_flit = {T1, HT0};
        #1;
        check("rm_cr1", 32'(b_pop), 1);
        cyc();
        check("rm_cr2", 32'(b_pop), 1);
        cyc();
        check("rm_cr_out", 32'(b_pop), 0);
        b_valid = 2'b00;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/noc_vc_link_arbiter.md
Name: noc_vc_link_arbiter

Overview:
- Output-side stage directly downstream of the per-VC flit interface FIFOs of a router output port.
- Arbitrates among the CHANNELS virtual-channel FIFO heads and pops the winning FIFO.
- Forwards one registered flit per cycle onto the inter-router link.
- Tracks per-VC downstream buffer credits so it never overruns the neighbour's input FIFO.
- Wormhole packet locking: once a head flit wins, the link stays with that VC until its tail flit is sent.

Parameters:
- CHANNELS, 2: number of virtual channels (≥1).
- FLIT_WIDTH, 32: flit width. Bit FLIT_WIDTH-1 = HEAD, bit FLIT_WIDTH-2 = TAIL; single-flit packet has both set.
- CREDITS, 8: downstream buffer depth per VC; initial credit count.
- CW, $clog2(CREDITS+1): credit counter width.

Ports:
- noc_clk  in  1  clock.
- noc_rst_n  in  1  synchronous active-low reset.
- i_clear  in  1  synchronous soft clear, same effect as reset.
- i_valid  in  CHANNELS  per-VC FIFO non-empty (FIFO sender valid).
- i_flit  in  CHANNELS×FLIT_WIDTH  per-VC FIFO head flit.
- o_pop  out  CHANNELS  one-hot pop to the granted FIFO (FIFO sender ready).
- o_valid  out  CHANNELS  one-hot registered link valid, bit = VC id.
- o_flit  out  FLIT_WIDTH  registered link flit.
- i_credit_return  in  CHANNELS  per-VC credit return from downstream, one credit per set bit per cycle.
- o_credit_err  out  1  sticky: credit returned while counter already at CREDITS.
- o_locked  out  1  packet lock held (status).

Behaviour:
- Reset/clear (noc_rst_n=0 or i_clear=1 at clock edge):
  - o_valid=0, o_flit=0, o_credit_err=0, o_locked=0.
  - Lock dropped; round-robin pointer = VC0 highest priority.
  - All credit counters = CREDITS.
  - Reset mid-packet drops the lock silently; no flit is emitted the following cycle.
- Eligibility: VC v is eligible iff i_valid[v] && credit[v]!=0.
- Unlocked grant:
  - Round-robin among eligible VCs, starting from the pointer.
  - Pointer moves to winner+1 (mod CHANNELS) after each grant.
- Locked grant:
  - Only the locked VC may be granted, and only when eligible.
  - Otherwise no grant that cycle; the link idles. Other VCs do not bypass the lock.
- o_pop is combinational from current state and inputs: o_pop[v]=1 exactly on the cycle v is granted; at most one bit set.
- Latency: flit popped in cycle N appears on o_flit/o_valid in cycle N+1. o_valid is 0 in any cycle following a no-grant cycle; o_flit holds its last value when o_valid=0.
- Lock state (IDLE/LOCKED):
  - IDLE→LOCKED when the granted flit has HEAD=1 and TAIL=0; the lock records that VC.
  - LOCKED→IDLE when the granted flit on the locked VC has TAIL=1.
  - HEAD=1, TAIL=1 flit is granted without locking.
  - Body flit (HEAD=0) granted in IDLE: forwarded, no lock change. This is an upstream protocol error; not flagged.
- o_locked = LOCKED state.
- Credits:
  - On grant of v: credit[v] decrements.
  - On i_credit_return[v]: credit[v] increments.
  - Grant and return on the same VC in the same cycle: counter unchanged.
  - Return with counter==CREDITS and no same-cycle grant on that VC: counter saturates at CREDITS, o_credit_err set next cycle, stays set until reset/clear.
  - Counter never underflows: zero credit makes the VC ineligible.
- No backpressure on the link side; throughput is one flit/cycle when credits allow.

Test Plan:
- Reset then idle:
  - Hold i_valid=0 → o_valid=0, o_pop=0, o_locked=0.
  - 8 returns on VC0 → o_credit_err=1 on the cycle after the first return.
- Single-flit packets (CHANNELS=2, CREDITS=8):
  - Both VCs continuously present HEAD|TAIL flits → grants alternate VC0,VC1,VC0…
  - o_valid alternates 01,10 one cycle after each pop.
- Wormhole lock:
  - VC0 sends a 4-flit packet (H, B, B, T) while VC1 is valid throughout → o_valid=01 for 4 consecutive cycles, then VC1 is granted.
  - o_locked=1 from the cycle after H through the cycle T is popped.
- Credit exhaustion (CREDITS=2):
  - VC0 streams 4 single-flit packets with no returns → 2 pops, then o_pop[0]=0.
  - A return on VC0 → exactly one more pop the next cycle.
  - Simultaneous pop and return → counter stays constant.
- Locked VC starved:
  - VC0 is locked mid-packet with credit 0 while VC1 is valid with credits → no grant to VC1, o_valid=0 until a VC0 credit returns.
- Reset mid-packet:
  - Assert noc_rst_n=0 for 1 cycle after VC0's head → o_locked=0, credits=CREDITS.
  - VC1 head is granted on the first cycle after reset.
